fifo_rd_accum: RTL
==================

FIFO_RD_ACCUM -- requirements
Module: fifo_rd_accum

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 8: words summed per result; legal range 2..256.
REQ-002 SHALL have port Rclk, input, 1 bit: the single clock; all state updates on posedge Rclk.
REQ-003 SHALL have port rrst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port Rempty_i, input, 1 bit: FIFO read-side empty flag.
REQ-005 SHALL have port Rdata_i, input, 8 bits: FIFO head word, first-word-fall-through, valid whenever Rempty_i=0.
REQ-006 SHALL have port Rinc_o, output, 1 bit: FIFO pop strobe; one word consumed per cycle high.
REQ-007 SHALL have port Acc_o, output, 16 bits: completed block sum.
REQ-008 SHALL have port Acc_valid_o, output, 1 bit: Acc_o holds an unconsumed result.
REQ-009 SHALL have port Acc_ready_i, input, 1 bit: downstream accepts Acc_o.
REQ-010 SHALL have port seq_err_o, output, 1 bit: sticky sequence-error flag.
REQ-011 SHALL have port err_cnt_o, output, 8 bits: sequence-error count.

Function
REQ-012 SHALL implement two states: ACCUM, HOLD.
REQ-013 SHALL drive Rinc_o combinationally = (state==ACCUM) && !Rempty_i; never high in HOLD or during reset.
REQ-014 In ACCUM, on a pop: sum <= sum + zero-extended Rdata_i (16-bit); cnt <= cnt + 1.
REQ-015 On a pop with cnt == BLOCK_LEN-1: Acc_o <= sum + Rdata_i, Acc_valid_o <= 1, sum <= 0, cnt <= 0, state -> HOLD, all in the same edge.
REQ-016 In ACCUM with Rempty_i=1: sum, cnt, state unchanged.
REQ-017 In HOLD: Acc_o and Acc_valid_o held stable until Acc_valid_o && Acc_ready_i at a clock edge.
REQ-018 On that handshake edge: Acc_valid_o <= 0, state -> ACCUM; popping resumes the next cycle (one bubble cycle minimum).
REQ-019 Acc_ready_i while Acc_valid_o=0 SHALL have no effect.
REQ-020 Latency: Acc_valid_o rises on the edge that pops the BLOCK_LEN-th word.
REQ-021 No overflow handling required: max sum 256*255 = 65280 fits 16 bits.

Reset
REQ-022 rrst=1 SHALL immediately, independent of Rclk, force: state=ACCUM, sum=0, cnt=0, Acc_o=0, Acc_valid_o=0, seq_err_o=0, err_cnt_o=0, checker "first word" flag set.
REQ-023 Reset asserted mid-block or in HOLD SHALL discard the partial sum or pending result; Rinc_o=0 while rrst=1.
REQ-024 First pop permitted on the first Rclk posedge after rrst deasserts.

Configuration
REQ-025 Macro SEQ_CHECK_EN SHALL compile in a sequence checker: first popped word after reset sets reference; each later popped word must equal previous popped word + 1 (mod 256).
REQ-026 With SEQ_CHECK_EN: on mismatch, seq_err_o <= 1 (sticky until reset), err_cnt_o increments, saturating at 255; reference always updates to the popped word.
REQ-027 Without SEQ_CHECK_EN: no checker logic; seq_err_o and err_cnt_o tied to 0.
REQ-028 Accumulate/handshake behaviour SHALL be identical with or without the macro.

Verification
REQ-029 Reset, BLOCK_LEN=8, Rempty_i=0, Rdata_i=1..8 on consecutive pops, Acc_ready_i=0 -> 8 Rinc_o pulses, Acc_o=36, Acc_valid_o=1, Rinc_o=0 while held.
REQ-030 From REQ-029 state, Acc_ready_i=1 one cycle -> Acc_valid_o=0 next edge; Rinc_o resumes the following cycle; next block 9..16 -> Acc_o=100.
REQ-031 Rempty_i toggled 1/0 every cycle, data 1..8 -> exactly 8 pops, no pop while empty, Acc_o=36.
REQ-032 BLOCK_LEN=256, Rdata_i=255 constant -> Acc_o=65280, no wrap.
REQ-033 rrst pulsed asynchronously (no Rclk edge) after 5 of 8 pops -> all outputs 0 immediately; next full block of 1..8 yields Acc_o=36.
REQ-034 SEQ_CHECK_EN defined, data 1,2,3,7,8 -> seq_err_o=1 after the 7 pop, err_cnt_o=1 (7->8 passes); macro undefined, same stimulus -> seq_err_o=0, err_cnt_o=0.

Source files
------------

// File: rtl/fifo_rd_accum.sv
// Pops a first-word-fall-through FIFO and sums every BLOCK_LEN words into one
// 16-bit result with a valid/ready handshake. Define SEQ_CHECK_EN to add the incrementing-data checker.
module fifo_rd_accum #(
    parameter int BLOCK_LEN = 8
) (
    input  logic        Rclk,
    input  logic        rrst,
    input  logic        Rempty_i,
    input  logic [7:0]  Rdata_i,
    output logic        Rinc_o,
    output logic [15:0] Acc_o,
    output logic        Acc_valid_o,
    input  logic        Acc_ready_i,
    output logic        seq_err_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [7:0] LAST_CNT = 8'(BLOCK_LEN - 1);

    state_t      state_q, state_d;
    logic [15:0] sum_q, sum_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        acc_valid_q, acc_valid_d;
    logic [15:0] sum_ext;
    logic        pop;

    // Reset is folded in so no pop is ever signalled while the block is held in reset.
    assign pop     = (state_q == ACCUM) && !Rempty_i && !rrst;
    assign sum_ext = sum_q + {8'h00, Rdata_i};

    always_ff @(posedge Rclk or posedge rrst) begin
        if (rrst) begin
            state_q     <= ACCUM;
            sum_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_valid_d = acc_valid_q;
        case (state_q)
            ACCUM: begin
                if (pop) begin
                    if (cnt_q == LAST_CNT) begin
                        acc_d       = sum_ext;
                        acc_valid_d = 1'b1;
                        sum_d       = '0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        sum_d = sum_ext;
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (acc_valid_q && Acc_ready_i) begin
                    acc_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign Rinc_o      = pop;
    assign Acc_o       = acc_q;
    assign Acc_valid_o = acc_valid_q;

`ifdef SEQ_CHECK_EN
    logic       first_q;
    logic [7:0] ref_q;
    logic       seq_err_q;
    logic [7:0] err_cnt_q;
    logic       mismatch;

    assign mismatch = !first_q && (Rdata_i != (ref_q + 8'd1));

    always_ff @(posedge Rclk or posedge rrst) begin
        if (rrst) begin
            first_q   <= 1'b1;
            ref_q     <= '0;
            seq_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else if (pop) begin
            first_q <= 1'b0;
            ref_q   <= Rdata_i;
            if (mismatch) begin
                seq_err_q <= 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign seq_err_o = seq_err_q;
    assign err_cnt_o = err_cnt_q;
`else
    assign seq_err_o = 1'b0;
    assign err_cnt_o = 8'h00;
`endif

endmodule
